// File: rtl/anb_smc_rd_arb.sv
// anb_smc_rd_arb: shares one SMC read port among N ANB read requesters.
// Address requests are granted round-robin into a one-entry output register
// and tagged with the requester index. Returned beats are steered back by id.
// A per-requester counter caps the number of accepted, unfinished bursts.
// Requester-side buses are packed arrays indexed by requester number.
module anb_smc_rd_arb #(
  parameter int N         = 4,
  parameter int MAX_OUTST = 4,
  parameter int AW        = 64,
  parameter int LW        = 14,
  parameter int DW        = 128,
  localparam int IDW      = $clog2(N),
  localparam int CW       = $clog2(MAX_OUTST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester side
  input  logic [N-1:0][AW-1:0]  m_addr,
  input  logic [N-1:0][LW-1:0]  m_len,
  input  logic [N-1:0]          m_avalid,
  input  logic [N-1:0]          m_ready,
  output logic [N-1:0]          m_aready,
  output logic [N-1:0][DW-1:0]  m_data,
  output logic [N-1:0]          m_last,
  output logic [N-1:0]          m_valid,
  // memory side
  output logic [IDW-1:0]        smc_aid,
  output logic [AW-1:0]         smc_addr,
  output logic [LW-1:0]         smc_len,
  output logic                  smc_avalid,
  output logic                  smc_ready,
  input  logic                  smc_aready,
  input  logic [IDW-1:0]        smc_id,
  input  logic [DW-1:0]         smc_data,
  input  logic [DW/8-1:0]       smc_strb,
  input  logic                  smc_valid,
  input  logic                  smc_last,
  output logic                  err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

  logic                  hold_v_q, hold_v_d;
  logic [IDW-1:0]        hold_aid_q, hold_aid_d;
  logic [AW-1:0]         hold_addr_q, hold_addr_d;
  logic [LW-1:0]         hold_len_q, hold_len_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [N-1:0]          elig_s;
  logic                  grant_v_s;
  logic [IDW-1:0]        grant_s;
  logic [IDW-1:0]        scan_s;
  logic                  load_en_s;
  logic                  addr_hs_s;
  logic [N-1:0]          id_hit_s;
  logic                  id_ok_s;
  logic                  data_hs_s;
  logic [N-1:0]          inc_s;
  logic [N-1:0]          dec_s;
  logic                  strb_unused_s;

  // Byte strobes carry no meaning on the read return path.
  assign strb_unused_s = ^smc_strb;

  assign smc_avalid = hold_v_q;
  assign smc_aid    = hold_aid_q;
  assign smc_addr   = hold_addr_q;
  assign smc_len    = hold_len_q;
  assign err        = err_q;

  // Eligibility and round-robin winner search starting at rr_q.
  always_comb begin
    grant_v_s = 1'b0;
    grant_s   = '0;
    scan_s    = '0;
    for (int i = 0; i < N; i++) begin
      elig_s[i] = m_avalid[i] && (cnt_q[i] < MAX_C);
    end
    for (int k = 0; k < N; k++) begin
      scan_s = IDW'((int'(rr_q) + k) % N);
      if (!grant_v_s && elig_s[scan_s]) begin
        grant_v_s = 1'b1;
        grant_s   = scan_s;
      end else begin
        grant_v_s = grant_v_s;
      end
    end
  end

  // Address grant: the winner sees aready whenever the hold register can load.
  always_comb begin
    load_en_s = !hold_v_q || smc_aready;
    addr_hs_s = grant_v_s && load_en_s && !rst;
    m_aready  = '0;
    if (addr_hs_s) begin
      m_aready[grant_s] = 1'b1;
    end else begin
      m_aready = '0;
    end
  end

  // Return-data steering by id; unknown ids are accepted and dropped.
  always_comb begin
    id_ok_s   = 1'b0;
    smc_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      id_hit_s[i] = (smc_id == IDW'(i));
      if (id_hit_s[i]) begin
        id_ok_s   = 1'b1;
        smc_ready = m_ready[i];
      end else begin
        id_ok_s   = id_ok_s;
      end
      m_valid[i] = smc_valid && id_hit_s[i];
      m_data[i]  = smc_data;
      m_last[i]  = smc_last;
    end
    data_hs_s = smc_valid && smc_ready;
  end

  // Next state for the hold register, pointer, counters and error flag.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_aid_d  = hold_aid_q;
    hold_addr_d = hold_addr_q;
    hold_len_d  = hold_len_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    err_d       = err_q || (smc_valid && !id_ok_s);

    if (addr_hs_s) begin
      hold_v_d    = 1'b1;
      hold_aid_d  = grant_s;
      hold_addr_d = m_addr[grant_s];
      hold_len_d  = m_len[grant_s];
      rr_d        = IDW'((int'(grant_s) + 1) % N);
    end else if (hold_v_q && smc_aready) begin
      hold_v_d    = 1'b0;
    end else begin
      hold_v_d    = hold_v_q;
    end

    for (int i = 0; i < N; i++) begin
      inc_s[i] = addr_hs_s && (grant_s == IDW'(i));
      // A zero count never decrements: beats left over from before a reset.
      dec_s[i] = data_hs_s && smc_last && id_hit_s[i] && (cnt_q[i] != '0);
      case ({inc_s[i], dec_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_aid_q  <= '0;
      hold_addr_q <= '0;
      hold_len_q  <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_aid_q  <= hold_aid_d;
      hold_addr_q <= hold_addr_d;
      hold_len_q  <= hold_len_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/anb_smc_rd_arb.md
# anb_smc_rd_arb

Read-path arbiter that shares one System Memory Controller read port (`smc_rd_if`) among N ANB read requesters (`anb_rd_if`). It grants address requests round-robin, tags each request with the requester index as `aid`, and steers returned data beats back to the requester named by `id`. It also limits outstanding bursts per requester. It sits between the per-engine ANB read masters and the SMC.

## Interface
Parameters:
- `N`, 4: number of requesters. Must be at least 2.
- `MAX_OUTST`, 4: maximum address-accepted, not-yet-completed bursts per requester. Must be at least 1.
- `ADDR_T`, `logic [63:0]`: address type, shared with both interfaces.
- `LEN_T`, `logic [13:0]`: burst length type.
- `DATA_T`, `logic [127:0]`: data beat type.

Ports:
- `clk`: in, 1 bit. Single clock for the whole block.
- `rst`: in, 1 bit. Synchronous, active-high reset.
- `m[N]`: `anb_rd_if.s` array. Requester side: `addr`, `len`, `avalid` and `ready` are inputs; `aready`, `data`, `last` and `valid` are outputs.
- `smc`: `smc_rd_if.m`. Memory side: drives `aid` (`clog2(N)` bits), `addr`, `len`, `avalid` and `ready`; receives `aready`, `id`, `data`, `strb`, `valid` and `last`.
- `err`: out, 1 bit. Sticky flag, set when a data beat arrives with `id >= N`.

## Operation
Address path:
- A one-entry output register (`hold_v`, `hold_aid`, `hold_addr`, `hold_len`) drives `smc.avalid`, `smc.aid`, `smc.addr` and `smc.len` directly.
- The register can load when `load_en = !hold_v || smc.aready`.
- Requester i is eligible when `m[i].avalid && cnt[i] < MAX_OUTST`.
- Round-robin selection: scan from pointer `rr` upward, modulo N. The first eligible requester is the winner g.
- `m[g].aready = load_en`. Every other `m[i].aready` is 0, and all are 0 when no requester is eligible.
- On a `m[g]` handshake:
  - the register loads `{1, g, m[g].addr, m[g].len}`;
  - `rr` becomes `(g+1) mod N`.
- If the register drains (`smc.avalid && smc.aready`) with no new winner, `hold_v` clears.
- `rr` is unchanged in any cycle without a grant.
- An ineligible requester is skipped. It is never blocked indefinitely once its counter drops.

Outstanding counters:
- `cnt[i]` is `clog2(MAX_OUTST+1)` bits wide.
- It increments on `m[i]` address handshake.
- It decrements on a data handshake with `smc.last && smc.id == i`.
- If both happen in the same cycle, the count is unchanged.
- The counter never wraps. Saturation is prevented by the eligibility rule.

Data path (purely combinational, zero latency):
- `m[i].valid = smc.valid && smc.id == i`.
- `m[i].data = smc.data` and `m[i].last = smc.last`, broadcast to all requesters.
- `smc.ready = m[smc.id].ready` when `smc.id < N`; otherwise `smc.ready = 1`, so the beat is dropped.
- `smc.strb` is ignored.
- `err` is set on `smc.valid && smc.id >= N`. It is cleared only by `rst`.

## Timing
- Reset values: `smc.avalid=0`, `hold_*=0`, all `m[i].aready=0`, `rr=0`, all `cnt=0`, `err=0`.
- During reset, `smc.ready` and `m[i].valid` still follow the combinational rules.
- Address latency: a request accepted in cycle t appears on `smc` in cycle t+1.
- Back-to-back throughput is 1 request per cycle while `smc.aready=1`.
- Once `smc.avalid` is asserted, `smc.aid`, `smc.addr` and `smc.len` stay stable until `smc.aready`, as AXI-style handshake rules require.
- No combinational path exists from `smc.aready` to `smc.avalid`. The path from `smc.aready` to `m[i].aready` is combinational and allowed.
- A burst's data may return while its address is still held. The counter decrements correctly whichever of the two handshakes comes first.
- Reset mid-operation: register, counters and pointer clear on the next edge. Data beats still in flight after reset are routed by `id` without counter effect; the counter stays at 0 and does not decrement.

## Test plan
- **Single requester**: N=4, only `m[2]` requests addr=0x1000, len=16 → `smc.avalid=1` one cycle after the `m[2]` handshake, with aid=2, addr=0x1000, len=16; `cnt[2]=1`.
- **Round-robin fairness**: all 4 requesters hold `avalid` and `smc.aready=1` → grant order 0,1,2,3,0,1…, one grant per cycle.
- **Outstanding limit**: MAX_OUTST=2, `m[1]` issues 3 requests with no data returned → third `aready` stays 0. After a beat with `last=1`, id=1 → third request is granted the next cycle.
- **Data steering and backpressure**: beats with id=3 and `m[3].ready=0` → `smc.ready=0` and only `m[3].valid=1`. Set `m[3].ready=1` → beat accepted; `last` decrements `cnt[3]`.
- **Stall hold**: `smc.aready=0` for 5 cycles with `hold_v=1` → `smc.aid/addr/len` unchanged and all `m[i].aready=0`.
- **Invalid id and reset**: N=3, beat with id=3 → `smc.ready=1`, `err=1` and stays set. Assert `rst` → `err=0`, `smc.avalid=0`, all counters 0.
